instr_prefetch_queue: RTL and testbench
=======================================

Name: instr_prefetch_queue

Overview:
- Fetch-side buffer between instruction memory and the decoder of the riscv core.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Buffers in-order responses, together with their PC, in a DEPTH-entry queue, and presents them to the decoder with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous reset, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, word aligned
- imem_req_ready  in  1  memory accepts request this cycle
- imem_resp_valid  in  1  response data valid; in order, at most one per cycle, ≥1 cycle after acceptance
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- out_valid  out  1  head entry valid
- out_pc  out  32  PC of head entry
- out_instr  out  32  head instruction; 32'h0000_0013 (NOP) when empty
- out_ready  in  1  decoder consumes head this cycle

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- All state updates on posedge clk. reset has priority over every other event.
- Reset values:
  - fetch_pc=RESET_PC, count=0, outstanding=0, drop_cnt=0, state=FETCH.
  - imem_req_valid=0 while reset is high; out_valid=0; out_pc=0; out_instr=NOP.
- Reset mid-operation: all counters are cleared. Instruction memory shares this reset and must drop its own in-flight responses.
- Credit rule: imem_req_valid=1 only when state==FETCH and count+outstanding<DEPTH.
- Request accepted (valid&&ready): fetch_pc+=4 (32-bit wrap from 0xFFFF_FFFC to 0), outstanding+=1.
- Response in FETCH: push {pc, imem_resp_data} at tail. The pc comes from a parallel in-order PC tag queue, so no address recompute is needed. outstanding-=1.
- Pop on out_valid&&out_ready: head advances.
  - Push and pop in the same cycle keep count unchanged.
  - Push into a full queue cannot occur, because the credit rule prevents it.
- Output data is registered queue contents; no combinational path from imem_resp_* to out_*. Minimum latency is request accept → response cycle → out_valid the next cycle.
- State machine:
  - FETCH: normal operation.
    - On redirect_valid: flush the queue (count=0, out_valid=0 next cycle) and set fetch_pc=redirect_pc&~3.
    - drop_cnt = outstanding, plus 1 if a request is accepted this cycle, minus 1 if a response arrives this cycle.
    - If drop_cnt>0 → DRAIN; else stay in FETCH and issue redirect_pc next cycle.
  - DRAIN: no requests issued.
    - Each response decrements drop_cnt and is discarded.
    - When drop_cnt reaches 0 (including the response-this-cycle case) → FETCH next cycle.
    - A further redirect in DRAIN updates fetch_pc and keeps drop_cnt accounting identical.
- Simultaneous events:
  - Redirect beats pop; the popped entry in that cycle still counts as consumed by the decoder.
  - A response in the redirect cycle belongs to the old stream and is dropped.
  - A request accepted in the redirect cycle uses the old address and is dropped later.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- Defined:
  - Adds outputs stat_flush_cnt[15:0] (redirect count, saturating) and stat_starve_cnt[31:0] (cycles with out_ready=1 and out_valid=0, wrapping).
  - Both counters are cleared by reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pkg:
  - NOP_INSTR=32'h0000_0013
  - fetch state enum {FETCH, DRAIN}
  - fetch_entry_t {pc[31:0], instr[31:0]}
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports push/pop/flush, full/empty/count.
  - Instantiated for the entry queue. A second instance, WIDTH=32, serves as the in-flight PC tag queue.

Test Plan:
- Reset, RESET_PC=0, memory ready always, latency 1, out_ready=1 → requests 0,4,8,…; out_pc sequence 0,4,8 with matching instr; one instruction/cycle after fill.
- out_ready=0 held, DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0; count=4; releasing out_ready resumes fetch.
- Latency 3, 2 outstanding, redirect_pc=0x100 → DRAIN; next 2 responses discarded; next request addr=0x100; first out_pc=0x100.
- Redirect with redirect_pc=0x103 and response arriving the same cycle → that response dropped; next fetch 0x100.
- fetch_pc=0xFFFF_FFFC accepted → next request 0x0000_0000.
- reset asserted with queue full and 3 outstanding → next cycle out_valid=0, out_instr=NOP, imem_req_addr=RESET_PC; with PREFETCH_STATS_EN, stat counters=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the riscv core front end.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Fetch bus bundle: instruction memory request/response, redirect, and decoder output channel.
interface instr_prefetch_queue_if;

    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, out_ready
    );

endinterface

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; head data is read straight from registered storage.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CNT_ONE << AW);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // NOTE: storage is deliberately not reset; the pointers alone define which words are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= r_count + (w_push ? CNT_ONE : '0) - (w_pop ? CNT_ONE : '0);
        end
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch, in-order buffering, redirect flush/drain.
// Optional PREFETCH_STATS_EN adds flush and starvation counters.
module instr_prefetch_queue
    import riscv_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    instr_prefetch_queue_if.master        bus
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]                   stat_flush_cnt,
    output logic [31:0]                   stat_starve_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);

    fetch_state_e r_state, w_state_nxt;
    logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
    logic [CW-1:0] r_drop_cnt, w_drop_cnt_nxt, w_drop_base, w_drop_calc;

    logic          w_entry_full, w_entry_empty, w_tag_full, w_tag_empty;
    logic [CW-1:0] w_entry_count, w_tag_count;
    logic [31:0]   w_tag_head;
    fetch_entry_t  w_head_entry, w_push_entry;
    logic          w_credit, w_req_fire, w_resp_keep, w_out_valid, w_pop;

    // Credit counts both buffered entries and requests still in flight, so a push can never overflow.
    assign w_credit = !w_entry_full && !w_tag_full &&
                      (({1'b0, w_entry_count} + {1'b0, w_tag_count}) < DEPTH_LIM);

    assign bus.imem_req_valid = !reset && (r_state == FETCH) && w_credit;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign w_req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign w_resp_keep = bus.imem_resp_valid && (r_state == FETCH) && !bus.redirect_valid && !w_tag_empty;

    assign w_out_valid   = !w_entry_empty;
    assign w_pop         = w_out_valid && bus.out_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_pc    = w_out_valid ? w_head_entry.pc    : 32'h0;
    assign bus.out_instr = w_out_valid ? w_head_entry.instr : NOP_INSTR;

    assign w_push_entry = '{pc: w_tag_head, instr: bus.imem_resp_data};

    sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_q (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_resp_keep),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (bus.redirect_valid),
        .o_head      (w_head_entry),
        .o_full      (w_entry_full),
        .o_empty     (w_entry_empty),
        .o_count     (w_entry_count)
    );

    // PC tags of live in-flight requests; a request accepted in a redirect cycle is stale and not tagged.
    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_q (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_req_fire && !bus.redirect_valid),
        .i_push_data (r_fetch_pc),
        .i_pop       (w_resp_keep),
        .i_flush     (bus.redirect_valid),
        .o_head      (w_tag_head),
        .o_full      (w_tag_full),
        .o_empty     (w_tag_empty),
        .o_count     (w_tag_count)
    );

    // NOTE: every variable gets its default before any branch so no path infers a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_drop_cnt_nxt = r_drop_cnt;
        w_drop_base    = (r_state == FETCH) ? w_tag_count : r_drop_cnt;
        w_drop_calc    = w_drop_base + (w_req_fire ? CNT_ONE : '0)
                                     - (bus.imem_resp_valid ? CNT_ONE : '0);
        if (bus.redirect_valid) begin
            w_fetch_pc_nxt = bus.redirect_pc & ~32'h3;
            w_drop_cnt_nxt = w_drop_calc;
            w_state_nxt    = (w_drop_calc != '0) ? DRAIN : FETCH;
        end else if (r_state == DRAIN) begin
            w_drop_cnt_nxt = w_drop_calc;
            if (w_drop_calc == '0) w_state_nxt = FETCH;
        end else if (w_req_fire) begin
            w_fetch_pc_nxt = r_fetch_pc + 32'd4;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drop_cnt <= w_drop_cnt_nxt;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] r_flush_cnt;
    logic [31:0] r_starve_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flush_cnt  <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (bus.redirect_valid && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
            if (bus.out_ready && !w_out_valid) r_starve_cnt <= r_starve_cnt + 32'd1;
        end
    end

    assign stat_flush_cnt  = r_flush_cnt;
    assign stat_starve_cnt = r_starve_cnt;
`endif

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomised bench: memory model, program-order scoreboard, directed redirect/credit/reset scenarios.
module tb_instr_prefetch_queue;
    import riscv_pkg::*;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    instr_prefetch_queue_if bus();

`ifdef PREFETCH_STATS_EN
    logic [15:0] stat_flush_cnt;
    logic [31:0] stat_starve_cnt;
`endif

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PREFETCH_STATS_EN
        ,
        .stat_flush_cnt  (stat_flush_cnt),
        .stat_starve_cnt (stat_starve_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int accept_cnt = 0;
    int pop_cnt = 0;
    int accept_at_reset = 0;
    int ready_pct = 100;
    int lat_min = 1;
    int lat_max = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- instruction memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pending[$];
    int          last_due = 0;
    int          stale_cnt = 0;
    logic [31:0] exp_req_addr = RESET_PC;

    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus.imem_req_ready = ($urandom_range(99) < ready_pct);
            if (pending.size() > 0 && pending[0].due <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = instr_of(pending[0].addr);
                void'(pending.pop_front());
                if (stale_cnt > 0) stale_cnt--;
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = $urandom;
            end
            @(negedge clk);
            if (reset) begin
                check("req_valid_in_reset", {31'h0, bus.imem_req_valid}, 32'h0);
                pending.delete();
                stale_cnt    = 0;
                last_due     = 0;
                exp_req_addr = RESET_PC;
            end else begin
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    int due;
                    check("req_addr", bus.imem_req_addr, exp_req_addr);
                    check("req_while_drain", stale_cnt, 0);
                    accept_cnt++;
                    exp_req_addr = exp_req_addr + 32'd4;
                    due = cyc + $urandom_range(lat_max, lat_min);
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pending.push_back('{bus.imem_req_addr, due});
                end
                if (bus.redirect_valid) begin
                    stale_cnt    = pending.size();
                    exp_req_addr = bus.redirect_pc & ~32'h3;
                end
            end
        end
    end

    // ---------------- scoreboard / output monitor ----------------
    fetch_entry_t exp_q[$];
    logic [31:0]  exp_next = RESET_PC;
    int           starve_model = 0;
    int           flush_model = 0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_next     = RESET_PC;
            starve_model = 0;
            flush_model  = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                fetch_entry_t e;
                e = exp_q.pop_front();
                check("out_pc", bus.out_pc, e.pc);
                check("out_instr", bus.out_instr, e.instr);
                pop_cnt++;
            end else if (!bus.out_valid) begin
                check("empty_nop", bus.out_instr, NOP_INSTR);
            end
            if (bus.out_ready && !bus.out_valid) starve_model++;
            if (bus.redirect_valid) begin
                exp_q.delete();
                exp_next = bus.redirect_pc & ~32'h3;
                if (flush_model < 65535) flush_model++;
            end
        end
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: exp_next, instr: instr_of(exp_next)});
            exp_next = exp_next + 32'd4;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        repeat (3) step();
        accept_at_reset = accept_cnt;
        reset = 1'b0;
        @(negedge clk);
        check("rst_req_addr", bus.imem_req_addr, RESET_PC);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_out_instr", bus.out_instr, NOP_INSTR);
        check("rst_out_pc", bus.out_pc, 32'h0);
`ifdef PREFETCH_STATS_EN
        check("rst_stat_flush", {16'h0, stat_flush_cnt}, 32'h0);
        check("rst_stat_starve", stat_starve_cnt, 32'h0);
`endif
    endtask

    task automatic redirect(input logic [31:0] pc);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int p0, a1;
        bit found;
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b1;

        // Streaming at latency 1: one instruction per cycle once filled.
        ready_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        repeat (10) step();
        p0 = pop_cnt;
        repeat (10) step();
        check("throughput_10_cycles", pop_cnt - p0, 10);

        // Misaligned redirect while a response is arriving every cycle.
        redirect(32'h0000_0103);
        repeat (15) step();

        // Credit limit with the decoder stalled.
        bus.out_ready = 1'b0;
        do_reset();
        repeat (20) step();
        check("credit_accepts", accept_cnt - accept_at_reset, DEPTH);
        @(negedge clk);
        check("credit_stall_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        step();
        bus.out_ready = 1'b1;
        a1 = accept_cnt;
        repeat (6) step();
        check("fetch_resumes", {31'h0, (accept_cnt > a1)}, 32'h1);

        // Latency 3 redirect with requests in flight: stale responses drained.
        lat_min = 3; lat_max = 3;
        do_reset();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        step();
        bus.redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (bus.out_valid) found = 1'b1;
            else step();
        end
        check("drain_first_out_seen", {31'h0, found}, 32'h1);
        check("drain_first_out_pc", bus.out_pc, 32'h0000_0100);
        repeat (10) step();

        // Address wrap past 0xFFFF_FFFC.
        lat_min = 1; lat_max = 2;
        redirect(32'hFFFF_FFF4);
        p0 = pop_cnt;
        repeat (20) step();
        check("wrap_progress", {31'h0, (pop_cnt - p0 >= 6)}, 32'h1);

        // Reset in the middle of operation with requests outstanding.
        bus.out_ready = 1'b0;
        lat_min = 4; lat_max = 6;
        repeat (6) step();
        do_reset();
        bus.out_ready = 1'b1;
        lat_min = 1; lat_max = 3;
        repeat (30) step();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                ready_pct = $urandom_range(100, 30);
                lat_min   = 1;
                lat_max   = $urandom_range(4, 1);
            end
            step();
            bus.out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(19) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = $urandom;
            end else begin
                bus.redirect_valid = 1'b0;
            end
        end
        step();
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        step();
        @(negedge clk);
        check("final_pop_activity", {31'h0, (pop_cnt > 1000)}, 32'h1);
`ifdef PREFETCH_STATS_EN
        check("stat_flush_cnt", {16'h0, stat_flush_cnt}, flush_model);
        check("stat_starve_cnt", stat_starve_cnt, starve_model);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
